mips_run_ctrl: RTL
==================

# mips_run_ctrl

Run sequencer for the single-cycle MIPS core. It streams a program image from a host port into instruction memory while holding the core in reset, then releases the core. It stops the core when the PC reaches a programmed end address and streams a fixed data-memory window back to the host. It replaces hand-driven reset, load and dump sequencing around `single_cycle_mips`.

## Interface
Parameters:
- `END_PC`, 32'h9c: PC value at which the run is considered complete.
- `DUMP_BASE`, 50: first dmem word index dumped.
- `DUMP_COUNT`, 21: number of dmem words dumped (1..255).
- `IMEM_AW`, 8: imem word-address width.
- `RST_HOLD`, 3: cycles `cpu_reset` stays high after load.
- `MAX_CYCLES`, 4096: run watchdog limit (only with `RUN_TIMEOUT_EN`).

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-low.
- `start` in 1: one-cycle request to begin a load/run/dump sequence.
- `load_len` in IMEM_AW+1: words to load; sampled on accepted `start`.
- `in_valid` in 1, `in_ready` out 1, `in_data` in 32: program word stream.
- `imem_we` out 1, `imem_addr` out IMEM_AW, `imem_wdata` out 32: imem write port.
- `cpu_reset` out 1: active-high core reset.
- `cpu_run` out 1: core clock enable; PC and register file update only when high.
- `cpu_pc` in 32: current core PC.
- `dmem_raddr` out 32: dmem word index, combinational read.
- `dmem_rdata` in 32: dmem read data.
- `out_valid` out 1, `out_ready` in 1, `out_data` out 32: dump stream.
- `busy`, `done`, `timeout` out 1: status.

## Operation
- States are IDLE, LOAD, HOLD, RUN, DUMP, DONE, plus FAIL when `RUN_TIMEOUT_EN` is defined.
- **IDLE / DONE / FAIL**
  - `start` moves to LOAD and clears the word index.
  - If `load_len==0`, the block goes directly to HOLD.
  - `start` is ignored in every other state.
- **LOAD**
  - `in_ready=1`.
  - On `in_valid&&in_ready`: `imem_we=1`, `imem_addr=idx`, `imem_wdata=in_data`, idx+1.
  - After the last word is accepted, the block moves to HOLD.
  - `cpu_reset=1` and `cpu_run=0` throughout LOAD.
- **HOLD**
  - `cpu_reset=1` for exactly RST_HOLD cycles, then the block enters RUN.
- **RUN**
  - `cpu_reset=0`.
  - `cpu_run = (cpu_pc != END_PC)`, decoded combinationally, so the instruction at END_PC never commits.
  - When `cpu_pc==END_PC`, the block moves to DUMP and clears idx.
- **DUMP**
  - `cpu_run=0`, `cpu_reset=0`; core state is frozen.
  - `dmem_raddr=DUMP_BASE+idx`, `out_data=dmem_rdata`, `out_valid=1`.
  - On `out_valid&&out_ready`, idx+1.
  - After word DUMP_COUNT-1 is accepted, the block moves to DONE.
- Status outputs:
  - `busy=1` in LOAD, HOLD, RUN and DUMP.
  - `done=1` only in DONE.
  - `timeout=1` only in FAIL.
- Index arithmetic is unsigned and sized IMEM_AW+1 bits; it never wraps because the terminal compare exits first.
- `imem_addr` takes the low IMEM_AW bits of idx.

## Timing
- Reset (`reset==0` at a rising edge) forces the following, from any state including mid-load or mid-dump:
  - state=IDLE, idx=0.
  - `cpu_reset=1`, `cpu_run=0`.
  - `in_ready=0`, `imem_we=0`, `out_valid=0`.
  - `busy=0`, `done=0`, `timeout=0`.
  - `dmem_raddr=0`, `out_data` is don't-care.
- Handshakes use valid/ready and transfer on a cycle where both are high.
- `out_valid` never drops without a transfer.
- `out_data` must hold stable while stalled, because dmem is frozen.
- LOAD accepts one word per cycle at most.
- Latency: accepted `start` to first `in_ready=1` is 1 cycle.
- The last load word to the first cycle with `cpu_reset=0` is RST_HOLD+1 cycles.
- The first PC==END_PC cycle to the first `out_valid` is 1 cycle.
- In IDLE, DONE and FAIL, `cpu_reset=1` so the core is quiescent.

## Configuration
- `RUN_TIMEOUT_EN` defined:
  - A 32-bit cycle counter clears on entry to RUN and increments each RUN cycle.
  - Reaching MAX_CYCLES without END_PC moves the block to FAIL with `timeout=1` and `cpu_run=0`.
  - An END_PC match in the same cycle as the limit takes priority and goes to DUMP.
- Undefined:
  - No counter, no FAIL state, and `timeout` is tied to 0.
  - RUN waits indefinitely.

## Structure
- `mips_run_pkg` holds:
  - the state enum (`ST_IDLE` … `ST_FAIL`);
  - default END_PC, DUMP_BASE and DUMP_COUNT constants;
  - the 32-bit word type.
- One sub-module, `run_watchdog`: a counter with clear, enable, limit compare and `expired` output.
  - It is instantiated only under `RUN_TIMEOUT_EN`.

## Test plan
- Load and run:
  - Stimulus: `start`, `load_len=40`, 40 back-to-back words.
  - Response: imem addresses 0..39 written in order; `cpu_reset` falls 4 cycles after the last word; `cpu_run=1` while PC≠0x9c.
- End-of-run dump:
  - Stimulus: model PC reaches 0x9c.
  - Response: `cpu_run=0` in that same cycle; `out_valid` the next cycle; 21 words from dmem indices 50..70; then `done=1`, `busy=0`.
- Backpressure:
  - Stimulus: `out_ready` toggled 1/0 every cycle during the dump.
  - Response: `out_data` stable while stalled; exactly 21 transfers; no skipped or duplicated index.
- Zero-length load:
  - Stimulus: `load_len=0`.
  - Response: no `imem_we`; HOLD then RUN.
  - Also: `start` asserted while busy is ignored.
- Reset mid-operation:
  - Stimulus: `reset=0` during LOAD after 5 words, and again during DUMP after 7 words.
  - Response: next cycle state IDLE, `cpu_reset=1`, `in_ready=0`, `out_valid=0`, `done=0`.
- Watchdog (with `RUN_TIMEOUT_EN`):
  - Stimulus: PC never reaches 0x9c, MAX_CYCLES=100.
  - Response: `timeout=1` after 100 RUN cycles, `cpu_run=0`, no dump.
  - Stimulus: PC equals 0x9c on cycle 100.
  - Response: DUMP entered, `timeout=0`.

Source files
------------

// File: rtl/mips_run_pkg.sv
// -----------------------------------------------------------------------------
// mips_run_pkg
// Shared types and default constants for the MIPS run sequencer
// (mips_run_ctrl) and its watchdog.
//   word_t          : 32-bit machine word.
//   state_e         : sequencer states. ST_FAIL is reachable only when
//                     RUN_TIMEOUT_EN is defined.
//   DEF_END_PC, DEF_DUMP_BASE, DEF_DUMP_COUNT : default run/dump window.
// -----------------------------------------------------------------------------
package mips_run_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_HOLD = 3'd2,
    ST_RUN  = 3'd3,
    ST_DUMP = 3'd4,
    ST_DONE = 3'd5,
    ST_FAIL = 3'd6
  } state_e;

  localparam word_t       DEF_END_PC     = 32'h0000_009c;
  localparam int unsigned DEF_DUMP_BASE  = 50;
  localparam int unsigned DEF_DUMP_COUNT = 21;

endpackage

// File: rtl/mips_run_ctrl_watchdog.sv
// -----------------------------------------------------------------------------
// run_watchdog
// 32-bit cycle counter that bounds the RUN phase of mips_run_ctrl.
// Only instantiated when RUN_TIMEOUT_EN is defined.
// Ports:
//   i_clk      : clock, rising edge
//   i_rst_n    : synchronous active-low reset
//   i_clr      : clear the count (has priority over i_en)
//   i_en       : count this cycle
//   o_expired  : the current enabled cycle is cycle number LIMIT
// -----------------------------------------------------------------------------
module run_watchdog #(
  parameter int unsigned LIMIT = 4096
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  logic [31:0] r_cnt;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of every other register. The reset is sampled
  // on the clock edge (synchronous), not in the sensitivity list.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + 32'd1;
    end
  end

  // r_cnt holds the number of completed enabled cycles, so the current
  // enabled cycle is number r_cnt+1; flag the one that reaches LIMIT.
  assign o_expired = i_en && (r_cnt >= (LIMIT - 32'd1));

endmodule

// File: rtl/mips_run_ctrl.sv
// -----------------------------------------------------------------------------
// mips_run_ctrl
// Run sequencer around single_cycle_mips: streams a program image into imem
// with the core held in reset, releases the core, stops it when the PC hits
// END_PC, then streams a fixed dmem window back to the host.
// Optional feature macro: RUN_TIMEOUT_EN (adds the RUN watchdog and ST_FAIL).
// Ports:
//   clk, reset (sync, active-low), start, load_len
//   in_valid/in_ready/in_data           : program word stream in
//   imem_we/imem_addr/imem_wdata        : imem write port
//   cpu_reset (active-high), cpu_run (core clock enable), cpu_pc
//   dmem_raddr/dmem_rdata               : combinational dmem read
//   out_valid/out_ready/out_data        : dump stream out
//   busy, done, timeout                 : status
// -----------------------------------------------------------------------------
module mips_run_ctrl
  import mips_run_pkg::*;
#(
  parameter word_t       END_PC     = DEF_END_PC,
  parameter int unsigned DUMP_BASE  = DEF_DUMP_BASE,
  parameter int unsigned DUMP_COUNT = DEF_DUMP_COUNT,
  parameter int unsigned IMEM_AW    = 8,
  parameter int unsigned RST_HOLD   = 3,
  parameter int unsigned MAX_CYCLES = 4096
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [IMEM_AW:0]   load_len,
  input  logic               in_valid,
  output logic               in_ready,
  input  word_t              in_data,
  output logic               imem_we,
  output logic [IMEM_AW-1:0] imem_addr,
  output word_t              imem_wdata,
  output logic               cpu_reset,
  output logic               cpu_run,
  input  word_t              cpu_pc,
  output word_t              dmem_raddr,
  input  word_t              dmem_rdata,
  output logic               out_valid,
  input  logic               out_ready,
  output word_t              out_data,
  output logic               busy,
  output logic               done,
  output logic               timeout
);

  localparam int unsigned      IW           = IMEM_AW + 1;
  localparam logic [IW-1:0]    LP_HOLD_LAST = IW'(RST_HOLD - 1);
  localparam logic [IW-1:0]    LP_DUMP_LAST = IW'(DUMP_COUNT - 1);

  state_e        r_state, w_state_nxt;
  logic [IW-1:0] r_idx,   w_idx_nxt;   // load index, hold counter, dump index
  logic [IW-1:0] r_len,   w_len_nxt;
  logic          w_at_end;

  assign w_at_end   = (cpu_pc == END_PC);
  assign imem_addr  = r_idx[IMEM_AW-1:0];
  assign imem_wdata = in_data;
  // dmem is frozen during DUMP, so passing read data straight through keeps
  // out_data stable while the host stalls.
  assign out_data   = dmem_rdata;

`ifdef RUN_TIMEOUT_EN
  logic w_wd_expired;

  run_watchdog #(
    .LIMIT (MAX_CYCLES)
  ) u_watchdog (
    .i_clk     (clk),
    .i_rst_n   (reset),
    .i_clr     (r_state != ST_RUN),
    .i_en      (r_state == ST_RUN),
    .o_expired (w_wd_expired)
  );
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_len   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_len   <= w_len_nxt;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_len_nxt   = r_len;
    cpu_reset   = 1'b1;
    cpu_run     = 1'b0;
    in_ready    = 1'b0;
    imem_we     = 1'b0;
    dmem_raddr  = '0;
    out_valid   = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    timeout     = 1'b0;

    case (r_state)
      ST_IDLE, ST_DONE, ST_FAIL: begin
        done = (r_state == ST_DONE);
`ifdef RUN_TIMEOUT_EN
        timeout = (r_state == ST_FAIL);
`endif
        if (start) begin
          w_len_nxt   = load_len;
          w_idx_nxt   = '0;
          w_state_nxt = (load_len == '0) ? ST_HOLD : ST_LOAD;
        end
      end

      ST_LOAD: begin
        busy     = 1'b1;
        in_ready = 1'b1;
        if (in_valid) begin
          imem_we = 1'b1;
          if (r_idx == (r_len - IW'(1))) begin
            // idx is reused as the HOLD cycle counter
            w_idx_nxt   = '0;
            w_state_nxt = ST_HOLD;
          end else begin
            w_idx_nxt = r_idx + IW'(1);
          end
        end
      end

      ST_HOLD: begin
        busy = 1'b1;
        if (r_idx == LP_HOLD_LAST) begin
          w_idx_nxt   = '0;
          w_state_nxt = ST_RUN;
        end else begin
          w_idx_nxt = r_idx + IW'(1);
        end
      end

      ST_RUN: begin
        busy      = 1'b1;
        cpu_reset = 1'b0;
        // Gate the enable in the same cycle the PC matches so the
        // instruction at END_PC never commits.
        cpu_run   = !w_at_end;
        if (w_at_end) begin
          w_idx_nxt   = '0;
          w_state_nxt = ST_DUMP;
        end
`ifdef RUN_TIMEOUT_EN
        else if (w_wd_expired) begin
          w_state_nxt = ST_FAIL;
        end
`endif
      end

      ST_DUMP: begin
        busy       = 1'b1;
        cpu_reset  = 1'b0;
        out_valid  = 1'b1;
        dmem_raddr = word_t'(DUMP_BASE) + word_t'(r_idx);
        if (out_ready) begin
          w_idx_nxt = r_idx + IW'(1);
          if (r_idx == LP_DUMP_LAST) begin
            w_state_nxt = ST_DONE;
          end
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

endmodule
